param_dp_ram: RTL and testbench
===============================

Name: param_dp_ram

Overview:
Parametrised successor to the team's single-port RAM. Port A is read/write with byte-lane write enables. Port B is read-only. Both read ports have registered outputs with a valid strobe. A reset-triggered clear engine sweeps every location to a known value before the block reports ready. It serves as the generic buffer memory for datapath blocks that need concurrent producer/consumer access.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8.
ADDR_W, 12, address width in bits.
DEPTH, 4096, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
RD_MODE, 0, port A same-address behaviour: 0 = read-first (old data), 1 = write-first (new data).
CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear sweep.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
init_done  out  1  high when the clear sweep is complete and ports are accepted.
a_en  in  1  port A access request.
a_we  in  DATA_W/8  port A byte-lane write enables; bit i covers data bits [8i+7:8i].
a_addr  in  ADDR_W  port A address.
a_din  in  DATA_W  port A write data.
a_dout  out  DATA_W  port A registered read data.
a_valid  out  1  one-cycle strobe qualifying a_dout.
b_en  in  1  port B read request.
b_addr  in  ADDR_W  port B address.
b_dout  out  DATA_W  port B registered read data.
b_valid  out  1  one-cycle strobe qualifying b_dout.
b_coll  out  1  high with b_valid when the port B read collided with a port A write to the same address.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to CLEAR; clear counter = 0.
  - init_done=0, a_dout=0, b_dout=0, a_valid=0, b_valid=0, b_coll=0.
  - Reset takes priority over everything, including mid-sweep and mid-access; the sweep restarts from address 0.
- FSM states: CLEAR, READY.
- CLEAR (rst=0):
  - Each cycle, write CLEAR_VAL to the counter address, then increment the counter.
  - After writing address DEPTH-1, go to READY on the next edge.
  - The sweep takes exactly DEPTH cycles after rst deasserts; init_done rises at the edge after the last clear write.
  - a_en and b_en are ignored: no writes, no valids.
- READY: stays in READY until rst.
- Port A write: a_en=1 and a_we!=0 at an edge writes only the enabled byte lanes of a_din to a_addr. Disabled lanes keep their old contents.
- Port A read: every a_en=1 cycle is a read, including write cycles.
  - a_dout is updated at the same edge as the request and is visible one cycle later (latency 1).
  - a_valid=1 for exactly that cycle.
  - When a_we!=0 and RD_MODE=0, a_dout = pre-write word.
  - When a_we!=0 and RD_MODE=1, a_dout = merged word (enabled lanes from a_din, others old).
- Port B read: b_en=1 gives b_dout = word at b_addr with latency 1, b_valid=1 for one cycle.
- Collision: when port A writes the same address that port B reads in the same cycle:
  - b_dout returns the pre-write word regardless of RD_MODE.
  - b_coll=1 alongside b_valid; otherwise b_coll=0.
- When en=0, a_dout/b_dout hold their last value, and valid/coll are 0.
- Out-of-range address (addr >= DEPTH):
  - Writes are dropped; memory is unchanged.
  - Reads return 0 with valid still asserted.
  - b_coll is never set for an out-of-range address.
- Back-to-back accesses every cycle are supported on both ports; there are no stalls in READY.

Test Plan:
1. Reset with DEPTH=16, release rst at cycle 0 -> init_done=0 for cycles 0-15, rises at cycle 16; reads of addresses 0-15 return CLEAR_VAL with a_valid.
2. DATA_W=16: write 0xABCD to addr 5 with a_we=2'b11, then write 0x1234 with a_we=2'b01, then read addr 5 -> a_dout=0xAB34 one cycle after the request, a_valid pulse of width 1.
3. RD_MODE=0: addr 3 holds 0x11; write 0x22 with a read in the same cycle -> a_dout=0x11. RD_MODE=1, same stimulus -> a_dout=0x22. A subsequent read returns 0x22 in both modes.
4. Port A writes 0x5A to addr 7 while port B reads addr 7 (old 0x00) -> b_dout=0x00, b_coll=1. Next cycle, b read addr 7 -> b_dout=0x5A, b_coll=0.
5. Assert rst at cycle 5 of the sweep after addr 7 was written 0x77 in READY -> init_done=0, full DEPTH-cycle sweep restarts, addr 7 reads CLEAR_VAL afterwards; a_en pulses during CLEAR produce no a_valid.
6. DEPTH=10, ADDR_W=4: write 0xFF to addr 12 -> addresses 0-9 are unchanged; a read of addr 12 returns 0 with a_valid=1.

Source files
------------

// File: rtl/param_dp_ram.sv
// param_dp_ram: dual-port RAM (port A read/write with byte lanes, port B read-only)
// with a reset-triggered clear sweep that gates both ports until init_done.
module param_dp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DEPTH = 4096,
    parameter int RD_MODE = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                a_en,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    output logic                a_valid,
    input  logic                b_en,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_dout,
    output logic                b_valid,
    output logic                b_coll
);
    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] a_old, a_new, b_old;
    logic a_ok, b_ok, a_wr, coll;
    assign a_ok = {1'b0, a_addr} < LIM;
    assign b_ok = {1'b0, b_addr} < LIM;
    assign a_old = mem[a_addr[IW-1:0]];
    assign b_old = mem[b_addr[IW-1:0]];
    assign a_wr = state == READY && a_en && |a_we && a_ok;
    assign coll = a_wr && b_en && a_addr == b_addr;
    always_comb begin
        a_new = a_old;
        for (int i = 0; i < NB; i++)
            if (a_we[i]) a_new[8*i +: 8] = a_din[8*i +: 8];
    end
    // Storage kept free of reset so it maps onto block RAM; the sweep does the clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) mem[clr_cnt[IW-1:0]] <= CLEAR_VAL;
            else if (a_wr) mem[a_addr[IW-1:0]] <= a_new;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            clr_cnt <= '0;
            init_done <= 1'b0;
            a_dout <= '0;
            b_dout <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            b_coll <= 1'b0;
        end else begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            b_coll <= 1'b0;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == LAST) begin
                    state <= READY;
                    init_done <= 1'b1;
                end
            end else begin
                if (a_en) begin
                    a_dout <= !a_ok ? '0 : (RD_MODE != 0 && |a_we) ? a_new : a_old;
                    a_valid <= 1'b1;
                end
                if (b_en) begin
                    b_dout <= b_ok ? b_old : '0;
                    b_valid <= 1'b1;
                    b_coll <= coll;
                end
            end
        end
    end
endmodule

// File: tb/tb_param_dp_ram.sv
// tb_param_dp_ram: directed and random checks of param_dp_ram against an array model
// (16-bit read-first and write-first instances, plus an 8-bit DEPTH=10 instance).
module tb_param_dp_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    localparam logic [15:0] CV = 16'hC3A5;
    localparam logic [7:0] YCV = 8'h3C;
    logic a_en, b_en;
    logic [1:0] a_we;
    logic [3:0] a_addr, b_addr;
    logic [15:0] a_din;
    logic x0_id, x0_av, x0_bv, x0_bc, x1_id, x1_av, x1_bv, x1_bc;
    logic [15:0] x0_ad, x0_bd, x1_ad, x1_bd;
    logic ya_en, yb_en;
    logic [0:0] ya_we;
    logic [3:0] ya_addr, yb_addr;
    logic [7:0] ya_din, y_ad, y_bd;
    logic y_id, y_av, y_bv, y_bc;

    param_dp_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .CLEAR_VAL(CV)) u_x0 (
        .clk(clk), .rst(rst), .init_done(x0_id), .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
        .a_din(a_din), .a_dout(x0_ad), .a_valid(x0_av), .b_en(b_en), .b_addr(b_addr),
        .b_dout(x0_bd), .b_valid(x0_bv), .b_coll(x0_bc));
    param_dp_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_MODE(1), .CLEAR_VAL(CV)) u_x1 (
        .clk(clk), .rst(rst), .init_done(x1_id), .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
        .a_din(a_din), .a_dout(x1_ad), .a_valid(x1_av), .b_en(b_en), .b_addr(b_addr),
        .b_dout(x1_bd), .b_valid(x1_bv), .b_coll(x1_bc));
    param_dp_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(10), .RD_MODE(0), .CLEAR_VAL(YCV)) u_y (
        .clk(clk), .rst(rst), .init_done(y_id), .a_en(ya_en), .a_we(ya_we), .a_addr(ya_addr),
        .a_din(ya_din), .a_dout(y_ad), .a_valid(y_av), .b_en(yb_en), .b_addr(yb_addr),
        .b_dout(y_bd), .b_valid(y_bv), .b_coll(y_bc));

    int checks = 0;
    int errors = 0;
    logic [15:0] m [16];
    logic [7:0] ym [10];
    int xcnt = 0;
    int ycnt = 0;
    logic [15:0] e_ad0 = '0, e_ad1 = '0, e_bd = '0;
    logic e_av = 0, e_bv = 0, e_bc = 0, e_id = 0;
    logic [7:0] ey_ad = '0, ey_bd = '0;
    logic ey_av = 0, ey_bv = 0, ey_bc = 0, ey_id = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setx(input logic e, input logic [1:0] w, input logic [3:0] ad,
                        input logic [15:0] d, input logic be, input logic [3:0] ba);
        a_en = e; a_we = w; a_addr = ad; a_din = d; b_en = be; b_addr = ba;
    endtask

    task automatic sety(input logic e, input logic w, input logic [3:0] ad,
                        input logic [7:0] d, input logic be, input logic [3:0] ba);
        ya_en = e; ya_we = w; ya_addr = ad; ya_din = d; yb_en = be; yb_addr = ba;
    endtask

    // Model one clock edge with the current inputs, then clock the DUTs and compare.
    task automatic step;
        logic [15:0] old, mrg;
        logic yok;
        if (rst) begin
            xcnt = 0; ycnt = 0;
            e_ad0 = '0; e_ad1 = '0; e_bd = '0; e_av = 0; e_bv = 0; e_bc = 0;
            ey_ad = '0; ey_bd = '0; ey_av = 0; ey_bv = 0; ey_bc = 0;
        end else begin
            e_av = 0; e_bv = 0; e_bc = 0;
            if (xcnt < 16) begin
                xcnt++;
                if (xcnt == 16) foreach (m[i]) m[i] = CV;
            end else begin
                old = m[a_addr];
                mrg = old;
                if (a_we[0]) mrg[7:0] = a_din[7:0];
                if (a_we[1]) mrg[15:8] = a_din[15:8];
                if (b_en) begin
                    e_bd = m[b_addr]; e_bv = 1;
                    e_bc = a_en && a_we != 0 && a_addr == b_addr;
                end
                if (a_en) begin
                    e_ad0 = old; e_ad1 = (a_we != 0) ? mrg : old; e_av = 1;
                    m[a_addr] = mrg;
                end
            end
            ey_av = 0; ey_bv = 0; ey_bc = 0;
            if (ycnt < 10) begin
                ycnt++;
                if (ycnt == 10) foreach (ym[i]) ym[i] = YCV;
            end else begin
                yok = ya_addr < 4'd10;
                if (yb_en) begin
                    ey_bd = (yb_addr < 4'd10) ? ym[yb_addr] : 8'h00; ey_bv = 1;
                    ey_bc = ya_en && ya_we[0] && yok && ya_addr == yb_addr;
                end
                if (ya_en) begin
                    ey_ad = yok ? ym[ya_addr] : 8'h00; ey_av = 1;
                    if (yok && ya_we[0]) ym[ya_addr] = ya_din;
                end
            end
        end
        e_id = xcnt >= 16;
        ey_id = ycnt >= 10;
        @(posedge clk);
        #1;
        chk("x0_init_done", 32'(x0_id), 32'(e_id));
        chk("x1_init_done", 32'(x1_id), 32'(e_id));
        chk("x0_a_valid", 32'(x0_av), 32'(e_av));
        chk("x1_a_valid", 32'(x1_av), 32'(e_av));
        chk("x0_a_dout", 32'(x0_ad), 32'(e_ad0));
        chk("x1_a_dout", 32'(x1_ad), 32'(e_ad1));
        chk("x0_b_valid", 32'(x0_bv), 32'(e_bv));
        chk("x1_b_valid", 32'(x1_bv), 32'(e_bv));
        chk("x0_b_dout", 32'(x0_bd), 32'(e_bd));
        chk("x1_b_dout", 32'(x1_bd), 32'(e_bd));
        chk("x0_b_coll", 32'(x0_bc), 32'(e_bc));
        chk("x1_b_coll", 32'(x1_bc), 32'(e_bc));
        chk("y_init_done", 32'(y_id), 32'(ey_id));
        chk("y_a_valid", 32'(y_av), 32'(ey_av));
        chk("y_a_dout", 32'(y_ad), 32'(ey_ad));
        chk("y_b_valid", 32'(y_bv), 32'(ey_bv));
        chk("y_b_dout", 32'(y_bd), 32'(ey_bd));
        chk("y_b_coll", 32'(y_bc), 32'(ey_bc));
    endtask

    initial begin
        setx(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
        sety(0, 0, 4'd0, 8'h0, 0, 4'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setx(1, 2'b11, 4'(i), 16'hDEAD, 1, 4'(i));
            step();
            chk("sweep_init_done", 32'(x0_id), 32'(i == 15));
        end
        for (int i = 0; i < 16; i++) begin
            setx(1, 2'b00, 4'(i), 16'h0, 1, 4'(15 - i));
            step();
            chk("clear_read", 32'(x0_ad), 32'(CV));
        end
        setx(1, 2'b11, 4'd5, 16'hABCD, 0, 4'd0); step();
        setx(1, 2'b01, 4'd5, 16'h1234, 0, 4'd0); step();
        setx(1, 2'b00, 4'd5, 16'h0, 0, 4'd0); step();
        chk("lane_merge", 32'(x0_ad), 32'h0000AB34);
        chk("lane_valid", 32'(x0_av), 32'd1);
        setx(0, 2'b00, 4'd0, 16'h0, 0, 4'd0); step();
        chk("valid_pulse", 32'(x0_av), 32'd0);
        setx(1, 2'b11, 4'd3, 16'h0011, 0, 4'd0); step();
        setx(1, 2'b11, 4'd3, 16'h0022, 0, 4'd0); step();
        chk("read_first", 32'(x0_ad), 32'h11);
        chk("write_first", 32'(x1_ad), 32'h22);
        setx(1, 2'b00, 4'd3, 16'h0, 0, 4'd0); step();
        chk("rf_after", 32'(x0_ad), 32'h22);
        chk("wf_after", 32'(x1_ad), 32'h22);
        setx(1, 2'b11, 4'd7, 16'h005A, 1, 4'd7); step();
        chk("coll_old", 32'(x1_bd), 32'(CV));
        chk("coll_flag", 32'(x0_bc), 32'd1);
        setx(0, 2'b00, 4'd0, 16'h0, 1, 4'd7); step();
        chk("coll_new", 32'(x0_bd), 32'h5A);
        chk("coll_clear", 32'(x0_bc), 32'd0);
        setx(1, 2'b11, 4'd7, 16'h0077, 0, 4'd0); step();
        setx(1, 2'b11, 4'd7, 16'h0099, 0, 4'd0);
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setx(i[0], 2'b11, 4'd7, 16'h0055, i[1], 4'd7);
            step();
            chk("clear_no_valid", 32'(x0_av), 32'(i == 15 ? 0 : 0));
        end
        setx(1, 2'b00, 4'd7, 16'h0, 0, 4'd0); step();
        chk("restart_clear", 32'(x0_ad), 32'(CV));
        setx(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
        sety(1, 1, 4'd12, 8'hFF, 0, 4'd0); step();
        for (int i = 0; i < 10; i++) begin
            sety(1, 0, 4'(i), 8'h0, 1, 4'(9 - i));
            step();
            chk("oor_untouched", 32'(y_ad), 32'(YCV));
        end
        sety(1, 0, 4'd12, 8'h0, 1, 4'd12); step();
        chk("oor_read_zero", 32'(y_ad), 32'd0);
        chk("oor_read_valid", 32'(y_av), 32'd1);
        sety(1, 1, 4'd12, 8'hAA, 1, 4'd12); step();
        chk("oor_no_coll", 32'(y_bc), 32'd0);
        for (int i = 0; i < 400; i++) begin
            setx(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) b_addr = a_addr;
            sety(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) yb_addr = ya_addr;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
